// File: rtl/carry_save_beat_accumulator.sv
// Purpose: sums weighted adder beats {cout_2, cout_1, sum} into one frame total, with a sticky overflow flag.
// Latency: out_valid rises the cycle after the frame's final beat is accepted.
// Backpressure: in_ready drops while a result waits; it holds until out_ready, with one bubble between frames.
module carry_save_beat_accumulator #(
    parameter int BEATS = 8,
    parameter int ACC_W = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum_in,
    input  logic             cout_1_in,
    input  logic             cout_2_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic [5:0]       w_partial6;
    logic [ACC_W-1:0] w_partial;
    logic [ACC_W:0]   w_acc_sum;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_in_rdy;

    // The carry weights 16 and 32 line up exactly with bit positions 4 and 5.
    assign w_partial6 = {cout_2_in, cout_1_in, sum_in};
    assign w_partial  = ACC_W'(w_partial6);
    // One extra bit so the carry out of the accumulator feeds the sticky overflow flag.
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_partial};
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_accept   = in_valid && w_in_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a frame closes on in_last or when the beat limit is reached
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_last || (BEATS == 1)) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = (in_last || (w_cnt_inc == CNT_W'(BEATS))) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: depends only on registered state, plus reset forcing in_ready low
    always_comb begin
        w_in_rdy  = !rst && (r_state != ST_HOLD);
        out_valid = (r_state == ST_HOLD);
    end

    assign in_ready  = w_in_rdy;
    assign out_acc   = r_acc;
    assign out_beats = r_cnt;
    assign out_ovf   = r_ovf;

    // Datapath: the first beat of a frame overwrites the previous frame's results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_acc <= w_partial;
                r_cnt <= CNT_W'(1);
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_sum[ACC_W-1:0];
                r_cnt <= w_cnt_inc;
                r_ovf <= r_ovf | w_acc_sum[ACC_W];
            end
        end
    end

endmodule
